victim_cache_ctrl: RTL and testbench

- Controller for the 4-way fully associative victim cache between L1 D-cache and L2.
- Holds tag, valid and dirty state for each way and sequences three operations: lookup, insert and dirty-victim writeback.
- On a lookup hit the line moves back to L1 and its way is freed. Lines evicted by L1 are inserted here. A dirty line displaced from the victim cache is written back to L2 before it is overwritten.
- The data array is registered inside this block.

---
 rtl/victim_cache_ctrl_pkg.sv | 28 ++
 rtl/victim_cache_ctrl_if.sv | 39 +++
 rtl/victim_cache_ctrl_lru.sv | 45 ++++
 rtl/victim_cache_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_victim_cache_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/victim_cache_ctrl_pkg.sv
// Shared types for the 4-way victim cache controller: FSM states, way index,
// line tag/data types and a lowest-set-bit encoder.
package victim_cache_types;

  localparam int TAG_W    = 27;
  localparam int DATA_W   = 256;
  localparam int NUM_WAYS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP   = 2'd1,
    WB     = 2'd2,
    INSERT = 2'd3
  } vc_state_e;

  typedef logic [1:0]        way_idx_t;
  typedef logic [TAG_W-1:0]  line_tag_t;
  typedef logic [DATA_W-1:0] line_data_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic way_idx_t first_set(input logic [NUM_WAYS-1:0] vec);
    first_set = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (vec[i]) first_set = way_idx_t'(i);
    end
  endfunction

endpackage

// File: rtl/victim_cache_ctrl_if.sv
// L1 request/response and L2 writeback signals of the victim cache controller.
// The slave modport is the controller's view, master is the environment's.
interface victim_cache_ctrl_if #(
  parameter int TAG_W  = 27,
  parameter int DATA_W = 256
);

  logic              vc_ready;
  logic              l1_lookup;
  logic [TAG_W-1:0]  l1_lookup_addr;
  logic              l1_insert;
  logic [TAG_W-1:0]  l1_insert_addr;
  logic [DATA_W-1:0] l1_insert_data;
  logic              l1_insert_dirty;
  logic              vc_resp;
  logic              vc_hit;
  logic [DATA_W-1:0] vc_rdata;
  logic              vc_rdirty;
  logic              vc_insert_done;
  logic              l2_write;
  logic [TAG_W-1:0]  l2_waddr;
  logic [DATA_W-1:0] l2_wdata;
  logic              l2_resp;

  modport slave (
    output vc_ready, vc_resp, vc_hit, vc_rdata, vc_rdirty, vc_insert_done,
           l2_write, l2_waddr, l2_wdata,
    input  l1_lookup, l1_lookup_addr, l1_insert, l1_insert_addr,
           l1_insert_data, l1_insert_dirty, l2_resp
  );

  modport master (
    input  vc_ready, vc_resp, vc_hit, vc_rdata, vc_rdirty, vc_insert_done,
           l2_write, l2_waddr, l2_wdata,
    output l1_lookup, l1_lookup_addr, l1_insert, l1_insert_addr,
           l1_insert_data, l1_insert_dirty, l2_resp
  );

endinterface

// File: rtl/victim_cache_ctrl_lru.sv
// 4x4 matrix LRU tracker. An update on way i sets row i (except bit i) and
// clears column i; the LRU way is the smallest row, ties to the lowest index.
module vc_lru_matrix
  import victim_cache_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     update,
  input  way_idx_t way,
  output way_idx_t lru
);

  logic [NUM_WAYS-1:0] row_q [NUM_WAYS];
  logic [NUM_WAYS-1:0] row_d [NUM_WAYS];
  logic [NUM_WAYS-1:0] min_row;

  always_comb begin
    for (int r = 0; r < NUM_WAYS; r++) begin
      row_d[r] = row_q[r];
      if (update) begin
        if (way_idx_t'(r) == way) row_d[r] = ~(NUM_WAYS'(1) << way);
        else                      row_d[r][way] = 1'b0;
      end
    end
  end

  always_comb begin
    lru     = '0;
    min_row = row_q[0];
    for (int i = 1; i < NUM_WAYS; i++) begin
      if (row_q[i] < min_row) begin
        min_row = row_q[i];
        lru     = way_idx_t'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_WAYS; r++) begin
      if (!rst_n) row_q[r] <= '0;
      else        row_q[r] <= row_d[r];
    end
  end

endmodule

// File: rtl/victim_cache_ctrl.sv
// 4-way fully associative victim cache controller: lookup, insert, swap and
// dirty-victim writeback to L2. Define VC_STATS_EN for hit/miss/writeback counters.
module victim_cache_ctrl #(
  parameter int TAG_W  = victim_cache_types::TAG_W,
  parameter int DATA_W = victim_cache_types::DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  victim_cache_ctrl_if.slave bus
`ifdef VC_STATS_EN
  ,
  output logic [31:0]        vc_hit_cnt,
  output logic [31:0]        vc_miss_cnt,
  output logic [31:0]        vc_wb_cnt
`endif
);

  import victim_cache_types::*;

  vc_state_e           state_q, state_d;
  logic [NUM_WAYS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [NUM_WAYS];
  logic [DATA_W-1:0]   data_q [NUM_WAYS];

  logic                hit_q, hit_d, swap_q, swap_d;
  way_idx_t            hit_way_q, hit_way_d, vict_way_q, vict_way_d;
  logic [TAG_W-1:0]    req_tag_q, req_tag_d;
  logic [DATA_W-1:0]   req_data_q, req_data_d;
  logic                req_dirty_q, req_dirty_d;

  logic                vc_ready_q, vc_ready_d, vc_resp_q, vc_resp_d;
  logic                vc_hit_q, vc_hit_d, vc_rdirty_q, vc_rdirty_d;
  logic [DATA_W-1:0]   vc_rdata_q, vc_rdata_d;
  logic                vc_insert_done_q, vc_insert_done_d;
  logic                l2_write_q, l2_write_d;
  logic [TAG_W-1:0]    l2_waddr_q, l2_waddr_d;
  logic [DATA_W-1:0]   l2_wdata_q, l2_wdata_d;

  logic                mem_we, lru_update, launch_insert, victim_wb;
  way_idx_t            lru_way, victim;
  logic [NUM_WAYS-1:0] lookup_match, ins_match, ins_valid;
  logic [TAG_W-1:0]    ins_tag;

  vc_lru_matrix u_lru (
    .clk    (clk),
    .rst_n  (rst_n),
    .update (lru_update),
    .way    (vict_way_q),
    .lru    (lru_way)
  );

  // Victim choice: in-place tag match, then the way a swap hit frees, then
  // the lowest invalid way, then LRU. A swap hit's way counts as already free.
  always_comb begin
    ins_tag      = (state_q == IDLE) ? bus.l1_insert_addr : req_tag_q;
    ins_valid    = valid_q;
    if (state_q == RESP && hit_q) ins_valid[hit_way_q] = 1'b0;
    lookup_match = '0;
    ins_match    = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      lookup_match[i] = valid_q[i]   && (tag_q[i] == bus.l1_lookup_addr);
      ins_match[i]    = ins_valid[i] && (tag_q[i] == ins_tag);
    end
    if (|ins_match)                   victim = first_set(ins_match);
    else if (state_q == RESP && hit_q) victim = hit_way_q;
    else if (!(&ins_valid))           victim = first_set(~ins_valid);
    else                              victim = lru_way;
    victim_wb = !(|ins_match) && ins_valid[victim] && dirty_q[victim];
  end

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d          = state_q;
    valid_d          = valid_q;
    dirty_d          = dirty_q;
    hit_d            = hit_q;
    hit_way_d        = hit_way_q;
    swap_d           = swap_q;
    vict_way_d       = vict_way_q;
    req_tag_d        = req_tag_q;
    req_data_d       = req_data_q;
    req_dirty_d      = req_dirty_q;
    vc_resp_d        = 1'b0;
    vc_hit_d         = 1'b0;
    vc_rdata_d       = vc_rdata_q;
    vc_rdirty_d      = vc_rdirty_q;
    vc_insert_done_d = 1'b0;
    l2_write_d       = l2_write_q;
    l2_waddr_d       = l2_waddr_q;
    l2_wdata_d       = l2_wdata_q;
    mem_we           = 1'b0;
    lru_update       = 1'b0;
    launch_insert    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (vc_ready_q) begin
          if (bus.l1_insert) begin
            req_tag_d   = bus.l1_insert_addr;
            req_data_d  = bus.l1_insert_data;
            req_dirty_d = bus.l1_insert_dirty;
          end
          if (bus.l1_lookup) begin
            hit_d     = |lookup_match;
            hit_way_d = first_set(lookup_match);
            swap_d    = bus.l1_insert;
            state_d   = RESP;
          end else if (bus.l1_insert) begin
            launch_insert = 1'b1;
          end
        end
      end
      RESP: begin
        vc_resp_d   = 1'b1;
        vc_hit_d    = hit_q;
        vc_rdata_d  = hit_q ? data_q[hit_way_q] : '0;
        vc_rdirty_d = hit_q && dirty_q[hit_way_q];
        if (hit_q) valid_d[hit_way_q] = 1'b0;
        if (swap_q) launch_insert = 1'b1;
        else        state_d       = IDLE;
      end
      WB: begin
        if (bus.l2_resp) begin
          l2_write_d = 1'b0;
          state_d    = INSERT;
        end
      end
      INSERT: begin
        mem_we              = 1'b1;
        lru_update          = 1'b1;
        valid_d[vict_way_q] = 1'b1;
        dirty_d[vict_way_q] = req_dirty_q;
        vc_insert_done_d    = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (launch_insert) begin
      vict_way_d = victim;
      if (victim_wb) begin
        l2_write_d = 1'b1;
        l2_waddr_d = tag_q[victim];
        l2_wdata_d = data_q[victim];
        state_d    = WB;
      end else begin
        state_d    = INSERT;
      end
    end

    vc_ready_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      valid_q          <= '0;
      dirty_q          <= '0;
      hit_q            <= 1'b0;
      hit_way_q        <= '0;
      swap_q           <= 1'b0;
      vict_way_q       <= '0;
      vc_ready_q       <= 1'b1;
      vc_resp_q        <= 1'b0;
      vc_hit_q         <= 1'b0;
      vc_rdata_q       <= '0;
      vc_rdirty_q      <= 1'b0;
      vc_insert_done_q <= 1'b0;
      l2_write_q       <= 1'b0;
      l2_waddr_q       <= '0;
      l2_wdata_q       <= '0;
    end else begin
      state_q          <= state_d;
      valid_q          <= valid_d;
      dirty_q          <= dirty_d;
      hit_q            <= hit_d;
      hit_way_q        <= hit_way_d;
      swap_q           <= swap_d;
      vict_way_q       <= vict_way_d;
      vc_ready_q       <= vc_ready_d;
      vc_resp_q        <= vc_resp_d;
      vc_hit_q         <= vc_hit_d;
      vc_rdata_q       <= vc_rdata_d;
      vc_rdirty_q      <= vc_rdirty_d;
      vc_insert_done_q <= vc_insert_done_d;
      l2_write_q       <= l2_write_d;
      l2_waddr_q       <= l2_waddr_d;
      l2_wdata_q       <= l2_wdata_d;
    end
  end

  // NOTE: tag/data storage and the captured request carry no reset; the valid
  // bits alone decide whether stored contents mean anything.
  always_ff @(posedge clk) begin
    req_tag_q   <= req_tag_d;
    req_data_q  <= req_data_d;
    req_dirty_q <= req_dirty_d;
    if (mem_we && rst_n) begin
      tag_q[vict_way_q]  <= req_tag_q;
      data_q[vict_way_q] <= req_data_q;
    end
  end

  assign bus.vc_ready       = vc_ready_q;
  assign bus.vc_resp        = vc_resp_q;
  assign bus.vc_hit         = vc_hit_q;
  assign bus.vc_rdata       = vc_rdata_q;
  assign bus.vc_rdirty      = vc_rdirty_q;
  assign bus.vc_insert_done = vc_insert_done_q;
  assign bus.l2_write       = l2_write_q;
  assign bus.l2_waddr       = l2_waddr_q;
  assign bus.l2_wdata       = l2_wdata_q;

`ifdef VC_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

  // Saturating counters, stepped on the same edges that emit vc_resp / ack L2.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (state_q == RESP &&  hit_q && hit_cnt_q  != '1) hit_cnt_d  = hit_cnt_q + 32'd1;
    if (state_q == RESP && !hit_q && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
    if (state_q == WB && bus.l2_resp && wb_cnt_q != '1) wb_cnt_d = wb_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign vc_hit_cnt  = hit_cnt_q;
  assign vc_miss_cnt = miss_cnt_q;
  assign vc_wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Directed self-checking bench for victim_cache_ctrl: lookup, insert, LRU
// replacement, dirty writeback, swap and reset during writeback.
module tb_victim_cache_ctrl;
  import victim_cache_types::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  victim_cache_ctrl_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

`ifdef VC_STATS_EN
  logic [31:0] vc_hit_cnt, vc_miss_cnt, vc_wb_cnt;
`endif

  victim_cache_ctrl #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef VC_STATS_EN
    ,
    .vc_hit_cnt  (vc_hit_cnt),
    .vc_miss_cnt (vc_miss_cnt),
    .vc_wb_cnt   (vc_wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic line_data_t pat(input logic [31:0] w);
    return {8{w}};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.vc_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, bus.vc_ready, 1);
  endtask

  task automatic do_lookup(input line_tag_t addr, input logic exp_hit,
                           input line_data_t exp_data, input logic exp_dirty,
                           input string tag);
    wait_ready(tag);
    bus.l1_lookup      = 1'b1;
    bus.l1_lookup_addr = addr;
    tick();
    bus.l1_lookup = 1'b0;
    check({tag, "_resp_early"}, bus.vc_resp, 0);
    tick();
    check({tag, "_resp"}, bus.vc_resp, 1);
    check({tag, "_hit"}, bus.vc_hit, exp_hit);
    if (exp_hit) begin
      check({tag, "_rdata"}, bus.vc_rdata, exp_data);
      check({tag, "_rdirty"}, bus.vc_rdirty, exp_dirty);
    end
    check({tag, "_ready_after"}, bus.vc_ready, 1);
  endtask

  task automatic do_insert(input line_tag_t addr, input line_data_t data,
                           input logic dirty, input string tag);
    wait_ready(tag);
    bus.l1_insert       = 1'b1;
    bus.l1_insert_addr  = addr;
    bus.l1_insert_data  = data;
    bus.l1_insert_dirty = dirty;
    tick();
    bus.l1_insert = 1'b0;
    check({tag, "_done_early"}, bus.vc_insert_done, 0);
    check({tag, "_no_wb"}, bus.l2_write, 0);
    tick();
    check({tag, "_done"}, bus.vc_insert_done, 1);
    check({tag, "_no_wb2"}, bus.l2_write, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n               = 1'b0;
    bus.l1_lookup       = 1'b0;
    bus.l1_lookup_addr  = '0;
    bus.l1_insert       = 1'b0;
    bus.l1_insert_addr  = '0;
    bus.l1_insert_data  = '0;
    bus.l1_insert_dirty = 1'b0;
    bus.l2_resp         = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_ready", bus.vc_ready, 1);
    check("rst_resp", bus.vc_resp, 0);
    check("rst_hit", bus.vc_hit, 0);
    check("rst_done", bus.vc_insert_done, 0);
    check("rst_l2_write", bus.l2_write, 0);
    check("rst_l2_waddr", bus.l2_waddr, 0);
    check("rst_l2_wdata", bus.l2_wdata, 0);
    check("rst_rdata", bus.vc_rdata, 0);
    rst_n = 1'b1;
    tick();

    // Lookup on an empty cache misses
    do_lookup(27'h0000123, 1'b0, '0, 1'b0, "empty_lookup");

    // Insert, hit, then the freed way misses
    do_insert(27'h0000123, pat(32'hA5A5A5A5), 1'b0, "ins_123");
    do_lookup(27'h0000123, 1'b1, pat(32'hA5A5A5A5), 1'b0, "hit_123");
    do_lookup(27'h0000123, 1'b0, '0, 1'b0, "refetch_123");

    // Fill four clean lines; fifth insert replaces LRU way 0 without writeback
    for (int i = 0; i < 4; i++)
      do_insert(line_tag_t'(32'h10 + i), pat(32'h1000_0010 + i), 1'b0, $sformatf("fill_%0d", i));
    do_insert(27'h14, pat(32'h1000_0014), 1'b0, "repl_14");
    do_lookup(27'h10, 1'b0, '0, 1'b0, "evicted_10");
    do_lookup(27'h13, 1'b1, pat(32'h1000_0013), 1'b0, "kept_13");

    // Fresh cache full of dirty lines; inserting 0x20 writes back LRU 0x10
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      do_insert(line_tag_t'(32'h10 + i), pat(32'hD000_0010 + i), 1'b1, $sformatf("dfill_%0d", i));
    wait_ready("wb_20");
    bus.l1_insert       = 1'b1;
    bus.l1_insert_addr  = 27'h20;
    bus.l1_insert_data  = pat(32'h2020_2020);
    bus.l1_insert_dirty = 1'b0;
    tick();
    bus.l1_insert = 1'b0;
    check("wb_20_wdata", bus.l2_wdata, pat(32'hD000_0010));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("wb_20_write_%0d", k), bus.l2_write, 1);
      check($sformatf("wb_20_waddr_%0d", k), bus.l2_waddr, 27'h10);
      check($sformatf("wb_20_noresp_%0d", k), bus.vc_resp, 0);
      check($sformatf("wb_20_ready_%0d", k), bus.vc_ready, 0);
      // A lookup raised while busy must be ignored
      bus.l1_lookup      = (k == 1);
      bus.l1_lookup_addr = 27'h11;
      if (k == 4) bus.l2_resp = 1'b1;
      tick();
    end
    bus.l1_lookup = 1'b0;
    bus.l2_resp   = 1'b0;
    check("wb_20_drop", bus.l2_write, 0);
    check("wb_20_done_early", bus.vc_insert_done, 0);
    tick();
    check("wb_20_done", bus.vc_insert_done, 1);
    check("wb_20_no_stray_resp", bus.vc_resp, 0);
    do_lookup(27'h10, 1'b0, '0, 1'b0, "gone_10");

    // Swap: lookup 0x11 hits way 1; 0x30 lands there with no writeback
    wait_ready("swap");
    bus.l1_lookup       = 1'b1;
    bus.l1_lookup_addr  = 27'h11;
    bus.l1_insert       = 1'b1;
    bus.l1_insert_addr  = 27'h30;
    bus.l1_insert_data  = pat(32'h3030_3030);
    bus.l1_insert_dirty = 1'b0;
    tick();
    bus.l1_lookup = 1'b0;
    bus.l1_insert = 1'b0;
    check("swap_resp_early", bus.vc_resp, 0);
    tick();
    check("swap_resp", bus.vc_resp, 1);
    check("swap_hit", bus.vc_hit, 1);
    check("swap_rdata", bus.vc_rdata, pat(32'hD000_0011));
    check("swap_rdirty", bus.vc_rdirty, 1);
    check("swap_no_wb", bus.l2_write, 0);
    check("swap_done_early", bus.vc_insert_done, 0);
    tick();
    check("swap_done", bus.vc_insert_done, 1);
    check("swap_no_wb2", bus.l2_write, 0);
    do_lookup(27'h30, 1'b1, pat(32'h3030_3030), 1'b0, "swap_30");

    // 0x40 refills freed way 1; LRU is now way 2 (dirty 0x12)
    do_insert(27'h40, pat(32'h4040_4040), 1'b1, "ins_40");
    wait_ready("wb_50");
    bus.l1_insert       = 1'b1;
    bus.l1_insert_addr  = 27'h50;
    bus.l1_insert_data  = pat(32'h5050_5050);
    bus.l1_insert_dirty = 1'b0;
    tick();
    bus.l1_insert = 1'b0;
    check("wb_50_write", bus.l2_write, 1);
    check("wb_50_waddr", bus.l2_waddr, 27'h12);
    check("wb_50_wdata", bus.l2_wdata, pat(32'hD000_0012));
    tick();
    check("wb_50_hold", bus.l2_write, 1);

    // Reset in the middle of the writeback
    rst_n = 1'b0;
    tick();
    check("rstwb_write", bus.l2_write, 0);
    check("rstwb_waddr", bus.l2_waddr, 0);
    check("rstwb_ready", bus.vc_ready, 1);
`ifdef VC_STATS_EN
    check("rstwb_hit_cnt", vc_hit_cnt, 0);
    check("rstwb_miss_cnt", vc_miss_cnt, 0);
    check("rstwb_wb_cnt", vc_wb_cnt, 0);
`endif
    rst_n = 1'b1;
    tick();
    do_lookup(27'h20, 1'b0, '0, 1'b0, "post_rst_20");
    do_lookup(27'h40, 1'b0, '0, 1'b0, "post_rst_40");
    do_lookup(27'h13, 1'b0, '0, 1'b0, "post_rst_13");
    check("post_rst_no_wb", bus.l2_write, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
